// File: rtl/demux_1x4_router.sv
// demux_1x4_router: steers one word stream to four channels, each behind its
// own DEPTH-entry FIFO so a stalled consumer only blocks its own traffic.

module demux_1x4_router_chan #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] head,
  output logic         valid,
  output logic         full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] CMAX = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign valid   = (count != '0);
  assign full    = (count == CMAX);
  assign do_push = push & ~full;
  assign do_pop  = pop & valid;
  assign head    = valid ? mem[rd_ptr] : '0;

  // Pointers are log2(DEPTH) wide, so increment wraps modulo DEPTH.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET && do_push)
      mem[wr_ptr] <= data;
  end
endmodule

module demux_1x4_router #(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] InData,
  input  logic [1:0]   Sel,
  input  logic         InValid,
  output logic         InReady,
  output logic [W-1:0] Out1,
  output logic [W-1:0] Out2,
  output logic [W-1:0] Out3,
  output logic [W-1:0] Out4,
  output logic [3:0]   OutValid,
  input  logic [3:0]   OutReady,
  output logic         AllEmpty
);
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  logic [3:0]   full;
  logic [3:0]   sel_hot;
  logic [3:0]   push;
  logic [3:0]   pop;
  logic [W-1:0] head [4];

  always_comb begin
    sel_hot = 4'b0000;
    unique case (Sel)
      2'd0: sel_hot = 4'b0001;
      2'd1: sel_hot = 4'b0010;
      2'd2: sel_hot = 4'b0100;
      2'd3: sel_hot = 4'b1000;
      default: sel_hot = 4'b0000;
    endcase
  end

  // Ready depends only on Sel and registered fill state, never on OutReady.
  assign InReady = ~RESET & ~|(full & sel_hot);
  assign push    = sel_hot & {4{InValid & InReady}};
  assign pop     = OutReady & OutValid;

  for (genvar k = 0; k < 4; k++) begin : g_chan
    demux_1x4_router_chan #(
      .W     (W),
      .DEPTH (DEPTH)
    ) u_chan (
      .CLK   (CLK),
      .RESET (RESET),
      .push  (push[k]),
      .pop   (pop[k]),
      .data  (InData),
      .head  (head[k]),
      .valid (OutValid[k]),
      .full  (full[k])
    );
  end

  assign Out1     = head[0];
  assign Out2     = head[1];
  assign Out3     = head[2];
  assign Out4     = head[3];
  assign AllEmpty = ~|OutValid;
endmodule

// File: tb/tb_demux_1x4_router.sv
// tb_demux_1x4_router: directed vector table, hand sequences for full/wrap
// corners, then a randomized run against per-channel queue models.

module tb_demux_1x4_router;
  localparam int W     = 4;
  localparam int DEPTH = 2;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [W-1:0] InData = '0;
  logic [1:0]   Sel = '0;
  logic         InValid = 1'b0;
  logic         InReady;
  logic [W-1:0] Out1;
  logic [W-1:0] Out2;
  logic [W-1:0] Out3;
  logic [W-1:0] Out4;
  logic [3:0]   OutValid;
  logic [3:0]   OutReady = '0;
  logic         AllEmpty;

  demux_1x4_router #(.W(W), .DEPTH(DEPTH)) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .InData   (InData),
    .Sel      (Sel),
    .InValid  (InValid),
    .InReady  (InReady),
    .Out1     (Out1),
    .Out2     (Out2),
    .Out3     (Out3),
    .Out4     (Out4),
    .OutValid (OutValid),
    .OutReady (OutReady),
    .AllEmpty (AllEmpty)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic        iv;
    logic [1:0]  sel;
    logic [3:0]  data;
    logic [3:0]  ordy;
    logic        ir;
    logic [3:0]  ov;
    logic [15:0] outs;
    logic        ae;
  } vec_t;

  int checks = 0;
  int failures = 0;

  logic [3:0] mq [4][$];
  logic [1:0] r_sel = '0;
  logic [3:0] r_data = '0;
  logic       r_iv = 1'b0;
  logic       hold = 1'b0;

  function automatic vec_t mk(logic rst, logic iv, logic [1:0] sel,
                              logic [3:0] data, logic [3:0] ordy,
                              logic ir, logic [3:0] ov,
                              logic [15:0] outs, logic ae);
    vec_t v;
    v.rst  = rst;
    v.iv   = iv;
    v.sel  = sel;
    v.data = data;
    v.ordy = ordy;
    v.ir   = ir;
    v.ov   = ov;
    v.outs = outs;
    v.ae   = ae;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v);
    RESET    = v.rst;
    InValid  = v.iv;
    Sel      = v.sel;
    InData   = v.data;
    OutReady = v.ordy;
    #1;
    chk({tag, " InReady"}, 32'(InReady), 32'(v.ir));
    @(posedge CLK);
    #1;
    chk({tag, " OutValid"}, 32'(OutValid), 32'(v.ov));
    chk({tag, " Outs"}, 32'({Out4, Out3, Out2, Out1}), 32'(v.outs));
    chk({tag, " AllEmpty"}, 32'(AllEmpty), 32'(v.ae));
  endtask

  task automatic rstep(input string tag, input logic rst, input logic iv,
                       input logic [1:0] s, input logic [3:0] d,
                       input logic [3:0] o);
    logic        exp_ir;
    logic [3:0]  exp_ov;
    logic [15:0] exp_outs;
    exp_ir = !rst && (mq[s].size() < DEPTH);
    RESET    = rst;
    InValid  = iv;
    Sel      = s;
    InData   = d;
    OutReady = o;
    #1;
    chk({tag, " InReady"}, 32'(InReady), 32'(exp_ir));
    if (rst) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
    end else begin
      for (int k = 0; k < 4; k++)
        if (o[k] && mq[k].size() > 0) void'(mq[k].pop_front());
      if (iv && exp_ir) mq[s].push_back(d);
    end
    hold = iv && !exp_ir && !rst;
    @(posedge CLK);
    #1;
    exp_ov   = '0;
    exp_outs = '0;
    for (int k = 0; k < 4; k++) begin
      if (mq[k].size() > 0) begin
        exp_ov[k] = 1'b1;
        exp_outs[k*4 +: 4] = mq[k][0];
      end
    end
    chk({tag, " OutValid"}, 32'(OutValid), 32'(exp_ov));
    chk({tag, " Outs"}, 32'({Out4, Out3, Out2, Out1}), 32'(exp_outs));
    chk({tag, " AllEmpty"}, 32'(AllEmpty), 32'(exp_ov == 4'b0000));
  endtask

  vec_t tbl [17];

  initial begin
    tbl[0]  = mk(1'b1, 1'b0, 2'd0, 4'h0, 4'h0, 1'b0, 4'b0000, 16'h0000, 1'b1);
    tbl[1]  = mk(1'b0, 1'b1, 2'd0, 4'hA, 4'h0, 1'b1, 4'b0001, 16'h000A, 1'b0);
    tbl[2]  = mk(1'b0, 1'b1, 2'd1, 4'hB, 4'h0, 1'b1, 4'b0011, 16'h00BA, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 2'd2, 4'hC, 4'h0, 1'b1, 4'b0111, 16'h0CBA, 1'b0);
    tbl[4]  = mk(1'b0, 1'b1, 2'd3, 4'hD, 4'h0, 1'b1, 4'b1111, 16'hDCBA, 1'b0);
    tbl[5]  = mk(1'b1, 1'b1, 2'd0, 4'h7, 4'hF, 1'b0, 4'b0000, 16'h0000, 1'b1);
    tbl[6]  = mk(1'b1, 1'b1, 2'd0, 4'h7, 4'hF, 1'b0, 4'b0000, 16'h0000, 1'b1);
    tbl[7]  = mk(1'b0, 1'b0, 2'd0, 4'h0, 4'h0, 1'b1, 4'b0000, 16'h0000, 1'b1);
    tbl[8]  = mk(1'b0, 1'b1, 2'd2, 4'h1, 4'h0, 1'b1, 4'b0100, 16'h0100, 1'b0);
    tbl[9]  = mk(1'b0, 1'b1, 2'd2, 4'h2, 4'h0, 1'b1, 4'b0100, 16'h0100, 1'b0);
    tbl[10] = mk(1'b0, 1'b1, 2'd2, 4'h3, 4'h0, 1'b0, 4'b0100, 16'h0100, 1'b0);
    tbl[11] = mk(1'b0, 1'b1, 2'd1, 4'h5, 4'h0, 1'b1, 4'b0110, 16'h0150, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 2'd2, 4'h3, 4'h4, 1'b0, 4'b0110, 16'h0250, 1'b0);
    tbl[13] = mk(1'b0, 1'b1, 2'd2, 4'h3, 4'h4, 1'b1, 4'b0110, 16'h0350, 1'b0);
    tbl[14] = mk(1'b0, 1'b0, 2'd2, 4'h0, 4'h4, 1'b1, 4'b0010, 16'h0050, 1'b0);
    tbl[15] = mk(1'b0, 1'b0, 2'd1, 4'h0, 4'h2, 1'b1, 4'b0000, 16'h0000, 1'b1);
    tbl[16] = mk(1'b0, 1'b0, 2'd0, 4'h0, 4'hF, 1'b1, 4'b0000, 16'h0000, 1'b1);

    for (int i = 0; i < 17; i++)
      run_vec($sformatf("vec%0d", i), tbl[i]);

    run_vec("pp1", mk(1'b0, 1'b1, 2'd1, 4'h1, 4'h0, 1'b1, 4'b0010, 16'h0010, 1'b0));
    run_vec("pp2", mk(1'b0, 1'b1, 2'd1, 4'h2, 4'h0, 1'b1, 4'b0010, 16'h0010, 1'b0));
    run_vec("pp3", mk(1'b0, 1'b1, 2'd1, 4'h9, 4'h2, 1'b0, 4'b0010, 16'h0020, 1'b0));
    run_vec("pp4", mk(1'b0, 1'b1, 2'd1, 4'h9, 4'h0, 1'b1, 4'b0010, 16'h0020, 1'b0));
    run_vec("pp5", mk(1'b0, 1'b0, 2'd1, 4'h0, 4'h2, 1'b0, 4'b0010, 16'h0090, 1'b0));
    run_vec("pp6", mk(1'b0, 1'b0, 2'd1, 4'h0, 4'h2, 1'b1, 4'b0000, 16'h0000, 1'b1));

    for (int i = 0; i < 16; i++)
      run_vec($sformatf("wrap%0d", i),
              mk(1'b0, 1'b1, 2'd3, 4'(i), 4'h8, 1'b1, 4'b1000,
                 {4'(i), 12'h000}, 1'b0));
    run_vec("wrap_end", mk(1'b0, 1'b0, 2'd3, 4'h0, 4'h8, 1'b1, 4'b0000, 16'h0000, 1'b1));

    for (int c = 0; c < 2000; c++) begin
      logic       rr;
      logic [3:0] ro;
      rr = ($urandom_range(0, 99) == 0);
      if (!hold) begin
        r_iv   = ($urandom_range(0, 3) != 0);
        r_sel  = 2'($urandom_range(0, 3));
        r_data = 4'($urandom_range(0, 15));
      end
      ro = 4'($urandom_range(0, 15));
      rstep($sformatf("rnd%0d", c), rr, r_iv, r_sel, r_data, ro);
    end
    for (int c = 0; c < DEPTH + 1; c++)
      rstep($sformatf("drain%0d", c), 1'b0, 1'b0, 2'd0, 4'h0, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
